// File: rtl/rotate_seq_pkg.sv
// rtl/rotate_seq_pkg.sv - shared widths, state type and reset constants for the rotate step sequencer
package rotate_seq_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam logic [DATA_W-1:0] PAT_RST = 8'h01;
  localparam logic [AMT_W-1:0]  AMT_RST = 3'd0;
  localparam logic [AMT_W-1:0]  AMT_MAX = 3'd7;

endpackage

// File: rtl/mod_m_counter.sv
// rtl/mod_m_counter.sv - modulo-M prescaler with enable and synchronous clear, pulses max_tick on the last count
module mod_m_counter #(
  parameter int M = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic max_tick
);

  localparam int CW = (M > 2) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  logic [CW-1:0] cnt;

  // Count 0..M-1 while enabled; clear has priority so a restart always begins at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign max_tick = en && (cnt == LAST);

endmodule

// File: rtl/rotate_step_sequencer.sv
// rtl/rotate_step_sequencer.sv - steps a barrel-shifter rotate amount per prescaled tick; ROTATE_BOUNCE_EN selects ping-pong direction
module rotate_step_sequencer
  import rotate_seq_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pattern_in,
  input  logic              load,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  output logic [DATA_W-1:0] sh_a,
  output logic [AMT_W-1:0]  sh_amt,
  output logic              sh_lr,
  input  logic [DATA_W-1:0] sh_y,
  output logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              step
);

  seq_state_t state;
  logic       tick;
  logic       presc_clr;

  assign busy = (state == RUN);

  // Prescaler restarts from zero whenever the sequencer enters RUN or drops back to IDLE.
  assign presc_clr = ((state == IDLE) && start) || ((state == RUN) && stop);

  mod_m_counter #(
    .M(TICK_DIV)
  ) u_presc (
    .clk     (clk),
    .rst     (reset),
    .en      (busy),
    .clr     (presc_clr),
    .max_tick(tick)
  );

  // Sequencer FSM and shifter-facing registers; load is applied last so it overrides a same-cycle tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sh_a   <= PAT_RST;
      sh_amt <= AMT_RST;
      sh_lr  <= 1'b0;
      q      <= PAT_RST;
      step   <= 1'b0;
    end else begin
      q    <= sh_y;
      step <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            sh_lr <= dir;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (tick) begin
            sh_amt <= sh_amt + 3'd1;
            step   <= 1'b1;
`ifdef ROTATE_BOUNCE_EN
            if (sh_amt == AMT_MAX) sh_lr <= ~sh_lr;
`endif
          end
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        sh_a   <= pattern_in;
        sh_amt <= AMT_RST;
        step   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rotate_step_sequencer.sv
// tb/tb_rotate_step_sequencer.sv - self-checking bench for rotate_step_sequencer with a rotating shifter in the loop
module tb_rotate_step_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pattern_in = 8'h00;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] sh_a;
  logic [2:0] sh_amt;
  logic       sh_lr;
  logic [7:0] sh_y;
  logic [7:0] q;
  logic       busy;
  logic       step;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] pat;
    logic       dir;
    int         nticks;
    logic [2:0] exp_amt;
    logic       exp_lr;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  function automatic logic [7:0] rot(input logic [7:0] a, input logic [2:0] n, input logic l);
    int s;
    s = int'(n);
    if (l) return (a << s) | (a >> (8 - s));
    else   return (a >> s) | (a << (8 - s));
  endfunction

  assign sh_y = rot(sh_a, sh_amt, sh_lr);

  rotate_step_sequencer #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pattern_in(pattern_in),
    .load      (load),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .sh_a      (sh_a),
    .sh_amt    (sh_amt),
    .sh_lr     (sh_lr),
    .sh_y      (sh_y),
    .q         (q),
    .busy      (busy),
    .step      (step)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < 40);
    if (!step) chk("step_timeout", 32'(n), 32'd4);
  endtask

  task automatic do_load(input logic [7:0] p);
    load = 1'b1;
    pattern_in = p;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start(input logic d);
    start = 1'b1;
    dir = d;
    cyc();
    start = 1'b0;
    dir = ~d;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    int n;
    logic bounce_lr;

    vecs[0] = '{pat: 8'h81, dir: 1'b1, nticks: 1, exp_amt: 3'd1, exp_lr: 1'b1, exp_q: 8'h03};
    vecs[1] = '{pat: 8'h81, dir: 1'b1, nticks: 7, exp_amt: 3'd7, exp_lr: 1'b1, exp_q: 8'hC0};
`ifdef ROTATE_BOUNCE_EN
    vecs[2] = '{pat: 8'hF0, dir: 1'b0, nticks: 9, exp_amt: 3'd1, exp_lr: 1'b1, exp_q: 8'hE1};
    bounce_lr = 1'b0;
`else
    vecs[2] = '{pat: 8'hF0, dir: 1'b0, nticks: 9, exp_amt: 3'd1, exp_lr: 1'b0, exp_q: 8'h78};
    bounce_lr = 1'b1;
`endif
    vecs[3] = '{pat: 8'h01, dir: 1'b1, nticks: 3, exp_amt: 3'd3, exp_lr: 1'b1, exp_q: 8'h08};
    vecs[4] = '{pat: 8'h3C, dir: 1'b0, nticks: 2, exp_amt: 3'd2, exp_lr: 1'b0, exp_q: 8'h0F};

    cyc();
    cyc();
    reset = 1'b0;

    // reset release: quiet outputs for several cycles
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rst_step", 32'(step), 32'd0);
    end
    chk("rst_q", 32'(q), 32'h01);
    chk("rst_amt", 32'(sh_amt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a", 32'(sh_a), 32'h01);
    chk("rst_lr", 32'(sh_lr), 32'd0);

    // table-driven runs
    for (int v = 0; v < 5; v++) begin
      do_load(vecs[v].pat);
      do_start(vecs[v].dir);
      chk("run_busy", 32'(busy), 32'd1);
      for (int k = 0; k < vecs[v].nticks; k++) begin
        wait_step(n);
        chk("step_period", 32'(n), 32'd4);
      end
      cyc();
      chk("run_amt", 32'(sh_amt), 32'(vecs[v].exp_amt));
      chk("run_lr", 32'(sh_lr), 32'(vecs[v].exp_lr));
      chk("run_q", 32'(q), 32'(vecs[v].exp_q));
      do_stop();
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_presc", 32'(dut.u_presc.cnt), 32'd0);
      cyc();
      cyc();
      chk("stop_q_hold", 32'(q), 32'(vecs[v].exp_q));
      chk("stop_amt_hold", 32'(sh_amt), 32'(vecs[v].exp_amt));
    end

    // start and stop together from IDLE: stop wins
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);
    cyc();
    chk("startstop_busy2", 32'(busy), 32'd0);

    // load coinciding with a tick: amt cleared, no step, prescaler keeps its phase
    do_load(8'h01);
    do_start(1'b1);
    wait_step(n);
    chk("ldtick_first", 32'(sh_amt), 32'd1);
    cyc();
    cyc();
    cyc();
    load = 1'b1;
    pattern_in = 8'h55;
    cyc();
    load = 1'b0;
    chk("ldtick_amt", 32'(sh_amt), 32'd0);
    chk("ldtick_step", 32'(step), 32'd0);
    chk("ldtick_a", 32'(sh_a), 32'h55);
    wait_step(n);
    chk("ldtick_period", 32'(n), 32'd4);
    chk("ldtick_amt2", 32'(sh_amt), 32'd1);
    do_stop();

    // asynchronous reset in the middle of a run
    do_load(8'h81);
    do_start(1'b0);
    for (int k = 0; k < 5; k++) wait_step(n);
    chk("mid_amt", 32'(sh_amt), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_q", 32'(q), 32'h01);
    chk("arst_amt", 32'(sh_amt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_step", 32'(step), 32'd0);
    chk("arst_a", 32'(sh_a), 32'h01);
    chk("arst_lr", 32'(sh_lr), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // direction behaviour across the 7->0 wrap
    do_load(8'h01);
    do_start(1'b1);
    for (int k = 0; k < 8; k++) wait_step(n);
    chk("wrap8_amt", 32'(sh_amt), 32'd0);
    chk("wrap8_lr", 32'(sh_lr), 32'(bounce_lr));
    for (int k = 0; k < 8; k++) wait_step(n);
    chk("wrap16_amt", 32'(sh_amt), 32'd0);
    chk("wrap16_lr", 32'(sh_lr), 32'd1);
    do_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
